lap_timer: RTL



---
 rtl/lap_timer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/lap_timer.sv
// Race lap timer: centisecond lap clock with last/best lap capture and lap counting
// for the HUD character ROMs. All outputs are registered.
module lap_timer #(
  parameter int CLK_FREQ_HZ   = 65000000,
  parameter int TICK_HZ       = 100,
  parameter int MAX_TIME      = 59999,
  parameter int NUM_LAPS      = 3,
  parameter int MIN_LAP_TICKS = 200
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        race_start,
  input  logic        finish_cross,
  input  logic        pause,
  output logic [15:0] current_lap_time,
  output logic [15:0] last_lap_time,
  output logic [15:0] best_lap_time,
  output logic [3:0]  lap_count,
  output logic        lap_done,
  output logic        race_done
);

  localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [15:0]      MAX_T    = 16'(MAX_TIME);
  localparam logic [15:0]      MIN_T    = 16'(MIN_LAP_TICKS);
  localparam logic [15:0]      NO_BEST  = 16'hFFFF;
  localparam logic [3:0]       LAPS     = 4'(NUM_LAPS);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  state_t           state, state_next;
  logic [PRE_W-1:0] presc, presc_next;
  logic [15:0]      cur_next, last_next, best_next;
  logic [3:0]       cnt_next;
  logic             lap_done_next, race_done_next;
  logic             active, tick, accept, final_lap, start;

  function automatic logic [15:0] sat_inc(input logic [15:0] t);
    return (t >= MAX_T) ? MAX_T : t + 16'd1;
  endfunction

  // Unsigned minimum; a tie keeps the existing best.
  function automatic logic [15:0] best_min(input logic [15:0] best, input logic [15:0] lap);
    return (lap < best) ? lap : best;
  endfunction

  // Timing runs whenever pause is low in RUNNING or PAUSED, so the release cycle
  // already counts and the tick suppressed on the pausing cycle is symmetric.
  assign active    = ((state == RUNNING) || (state == PAUSED)) && !pause;
  assign tick      = active && (presc == PRE_LAST);
  assign accept    = (state == RUNNING) && finish_cross && (current_lap_time >= MIN_T);
  assign final_lap = ((lap_count + 4'd1) == LAPS);
  assign start     = race_start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (race_start) state_next = RUNNING;
      RUNNING: begin
        if (accept && final_lap) state_next = DONE;
        else if (pause)          state_next = PAUSED;
      end
      PAUSED:  if (!pause) state_next = RUNNING;
      DONE:    if (race_start) state_next = RUNNING;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    presc_next     = presc;
    cur_next       = current_lap_time;
    last_next      = last_lap_time;
    best_next      = best_lap_time;
    cnt_next       = lap_count;
    lap_done_next  = 1'b0;
    race_done_next = (state_next == DONE);
    if (start) begin
      presc_next = '0;
      cur_next   = 16'd0;
      last_next  = 16'd0;
      best_next  = NO_BEST;
      cnt_next   = 4'd0;
    end else if (accept) begin
      last_next     = current_lap_time;
      best_next     = best_min(best_lap_time, current_lap_time);
      cnt_next      = lap_count + 4'd1;
      lap_done_next = 1'b1;
      if (!final_lap) begin
        cur_next   = 16'd0;
        presc_next = '0;
      end
    end else if (active) begin
      presc_next = tick ? '0 : presc + 1'b1;
      if (tick) cur_next = sat_inc(current_lap_time);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      presc            <= '0;
      current_lap_time <= 16'd0;
      last_lap_time    <= 16'd0;
      best_lap_time    <= NO_BEST;
      lap_count        <= 4'd0;
      lap_done         <= 1'b0;
      race_done        <= 1'b0;
    end else begin
      presc            <= presc_next;
      current_lap_time <= cur_next;
      last_lap_time    <= last_next;
      best_lap_time    <= best_next;
      lap_count        <= cnt_next;
      lap_done         <= lap_done_next;
      race_done        <= race_done_next;
    end
  end

endmodule
